demapper: RTL and testbench

Receive-side counterpart of the sender mapper. It takes the serial line bit stream from the serial receiver and finds frame alignment by hunting for the FAS byte. It then extracts payload bytes to the client RX FIFO and checks each frame's CRC-8 against the value carried in the following frame. It sits between the serial receiver and the client AXIS FIFO in the receiver path.

---
 rtl/demapper_pkg.sv | 21 ++
 rtl/demapper_fas_sync.sv | 94 +++++++++
 rtl/demapper.sv | 109 ++++++++++
 tb/tb_demapper.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demapper_pkg.sv
// Shared definitions for the receive-side demapper: lock FSM encoding,
// default frame constants (also used by the mapper) and the CRC-8 bit step.
package demapper_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PRESYNC = 2'd1,
    SYNC    = 2'd2
  } lock_state_t;

  localparam logic [7:0] DEF_FAS_BYTE = 8'hF6;
  localparam logic [7:0] DEF_CRC_POLY = 8'h07;

  // One MSB-first CRC-8 step: init 0, no reflection, no final XOR.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                           input logic       din,
                                           input logic [7:0] poly);
    return {crc[6:0], 1'b0} ^ ((crc[7] ^ din) ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/demapper_fas_sync.sv
// Frame alignment: serial shift register, bit/byte position counters and the
// HUNT/PRESYNC/SYNC lock machine driven by the FAS byte.
module demap_fas_sync
  import demapper_pkg::*;
#(
  parameter int         FRAME_BYTES = 16,
  parameter int         IDX_W       = 4,
  parameter logic [7:0] FAS_BYTE    = DEF_FAS_BYTE,
  parameter int         LOSS_THRESH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             byte_done,
  output logic [IDX_W-1:0] byte_idx,
  output logic [7:0]       rx_byte,
  output lock_state_t      state,
  output logic             locked
);

  localparam int               MISS_W   = $clog2(LOSS_THRESH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  logic [6:0]        sr;
  logic [2:0]        bit_cnt;
  logic [IDX_W-1:0]  byte_cnt;
  logic [MISS_W-1:0] miss_cnt;
  logic              fas_hit;
  logic              frame_start;

  // The byte seen this cycle includes the bit currently on the line.
  assign rx_byte     = {sr, bit_in};
  assign fas_hit     = (rx_byte == FAS_BYTE);
  assign byte_done   = bit_valid && (bit_cnt == 3'd7);
  assign frame_start = byte_done && (byte_cnt == '0);
  assign byte_idx    = byte_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sr       <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      miss_cnt <= '0;
      state    <= HUNT;
      locked   <= 1'b0;
    end else if (bit_valid) begin
      sr      <= rx_byte[6:0];
      bit_cnt <= bit_cnt + 3'd1;
      if (byte_done)
        byte_cnt <= (byte_cnt == LAST_IDX) ? '0 : byte_cnt + IDX_W'(1);

      case (state)
        // A hit lands on the FAS LSB, so the next bit opens byte 1.
        HUNT: begin
          if (fas_hit) begin
            state    <= PRESYNC;
            bit_cnt  <= '0;
            byte_cnt <= IDX_W'(1);
            miss_cnt <= '0;
          end
        end
        PRESYNC: begin
          if (frame_start) begin
            if (fas_hit) begin
              state  <= SYNC;
              locked <= 1'b1;
            end else begin
              state <= HUNT;
            end
          end
        end
        SYNC: begin
          if (frame_start) begin
            if (fas_hit) begin
              miss_cnt <= '0;
            end else if (miss_cnt == MISS_W'(LOSS_THRESH - 1)) begin
              state    <= HUNT;
              locked   <= 1'b0;
              miss_cnt <= '0;
            end else begin
              miss_cnt <= miss_cnt + MISS_W'(1);
            end
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/demapper.sv
// Receive demapper top: frame alignment plus payload extraction to the client
// FIFO and CRC-8 checking of each frame against the next frame's byte 1.
module demapper
  import demapper_pkg::*;
#(
  parameter int         FRAME_BYTES = 16,
  parameter logic [7:0] FAS_BYTE    = DEF_FAS_BYTE,
  parameter logic [7:0] CRC_POLY    = DEF_CRC_POLY,
  parameter int         LOSS_THRESH = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_frame_data,
  input  logic       i_frame_data_valid,
  output logic [7:0] o_pyld_data,
  output logic       o_pyld_data_valid,
  input  logic       i_fifo_full,
  output logic       o_frame_locked,
  output logic       o_crc_err,
  output logic [7:0] o_crc_err_cnt,
  output logic       o_ovf
);

  localparam int               IDX_W    = $clog2(FRAME_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  logic             byte_done;
  logic [IDX_W-1:0] byte_idx;
  logic [7:0]       rx_byte;
  lock_state_t      state;
  logic             locked;

  logic [7:0] crc_run;
  logic [7:0] crc_prev;
  logic [7:0] crc_next;
  logic       prev_ok;
  logic       in_payload;

  demap_fas_sync #(
    .FRAME_BYTES (FRAME_BYTES),
    .IDX_W       (IDX_W),
    .FAS_BYTE    (FAS_BYTE),
    .LOSS_THRESH (LOSS_THRESH)
  ) u_fas_sync (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .bit_in    (i_frame_data),
    .bit_valid (i_frame_data_valid),
    .byte_done (byte_done),
    .byte_idx  (byte_idx),
    .rx_byte   (rx_byte),
    .state     (state),
    .locked    (locked)
  );

  assign o_frame_locked = locked;
  assign in_payload     = (byte_idx >= IDX_W'(2));

  always_comb begin
    crc_next = crc8_step(crc_run, i_frame_data, CRC_POLY);
  end

  // While hunting there is no trusted frame, so the CRC history is discarded
  // and the first frame after relock is never compared.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      crc_run           <= '0;
      crc_prev          <= '0;
      prev_ok           <= 1'b0;
      o_pyld_data       <= '0;
      o_pyld_data_valid <= 1'b0;
      o_ovf             <= 1'b0;
      o_crc_err         <= 1'b0;
      o_crc_err_cnt     <= '0;
    end else begin
      o_pyld_data_valid <= 1'b0;
      o_ovf             <= 1'b0;
      o_crc_err         <= 1'b0;
      if (state == HUNT) begin
        crc_run <= '0;
        prev_ok <= 1'b0;
      end else if (i_frame_data_valid) begin
        if (in_payload) begin
          if (byte_done && (byte_idx == LAST_IDX)) begin
            crc_prev <= crc_next;
            prev_ok  <= 1'b1;
            crc_run  <= '0;
          end else begin
            crc_run <= crc_next;
          end
        end
        if (byte_done && (byte_idx == IDX_W'(1)) && prev_ok && (rx_byte != crc_prev)) begin
          o_crc_err <= 1'b1;
          if (o_crc_err_cnt != 8'hFF)
            o_crc_err_cnt <= o_crc_err_cnt + 8'd1;
        end
        if (byte_done && in_payload && (state == SYNC)) begin
          if (i_fifo_full) begin
            o_ovf <= 1'b1;
          end else begin
            o_pyld_data       <= rx_byte;
            o_pyld_data_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_demapper.sv
// Self-checking bench for demapper: directed frame sequences with random
// content, compared every cycle against a frame-position reference model.
module tb_demapper;

  localparam int         FB   = 16;
  localparam logic [7:0] FAS  = 8'hF6;
  localparam logic [7:0] POLY = 8'h07;
  localparam int         LOSS = 3;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_frame_data = 1'b0;
  logic       i_frame_data_valid = 1'b0;
  logic       i_fifo_full = 1'b0;
  logic [7:0] o_pyld_data;
  logic       o_pyld_data_valid;
  logic       o_frame_locked;
  logic       o_crc_err;
  logic [7:0] o_crc_err_cnt;
  logic       o_ovf;

  demapper #(
    .FRAME_BYTES (FB),
    .FAS_BYTE    (FAS),
    .CRC_POLY    (POLY),
    .LOSS_THRESH (LOSS)
  ) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_frame_data       (i_frame_data),
    .i_frame_data_valid (i_frame_data_valid),
    .o_pyld_data        (o_pyld_data),
    .o_pyld_data_valid  (o_pyld_data_valid),
    .i_fifo_full        (i_fifo_full),
    .o_frame_locked     (o_frame_locked),
    .o_crc_err          (o_crc_err),
    .o_crc_err_cnt      (o_crc_err_cnt),
    .o_ovf              (o_ovf)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;
  int seen_valid, seen_ovf, seen_err;

  // Reference model: alignment is a frame-start bit index, not counters.
  int         m_mode;
  longint     m_idx;
  longint     m_fs;
  logic [7:0] m_win;
  int         m_misses;
  bit         m_prev_ok;
  logic [7:0] m_crc_prev;
  logic [7:0] m_pay[$];
  logic       e_valid, e_ovf, e_err, e_locked;
  logic [7:0] e_data, e_cnt;

  logic [7:0] pay[$];
  logic [7:0] tx_crc;

  function automatic logic [7:0] crc8_q(input logic [7:0] q[$]);
    logic [7:0] c;
    c = 8'h00;
    foreach (q[j])
      for (int i = 7; i >= 0; i--)
        c = {c[6:0], 1'b0} ^ ((c[7] ^ q[j][i]) ? POLY : 8'h00);
    return c;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_fs = 0; m_win = 8'h00; m_misses = 0;
    m_prev_ok = 0; m_crc_prev = 8'h00; m_pay.delete();
    e_valid = 0; e_ovf = 0; e_err = 0; e_locked = 0; e_data = 8'h00; e_cnt = 8'h00;
  endtask

  task automatic model_hunt();
    m_mode = 0; m_prev_ok = 0; m_pay.delete(); m_misses = 0;
  endtask

  task automatic model_step(input logic b, input logic v, input logic full);
    longint p;
    int     byte_no;
    e_valid = 0; e_ovf = 0; e_err = 0;
    if (v) begin
      m_win = {m_win[6:0], b};
      if (m_mode == 0) begin
        if (m_win == FAS) begin
          m_mode = 1;
          m_fs   = m_idx - 7;
        end
      end else begin
        p = (m_idx - m_fs) % (8 * FB);
        if (p % 8 == 7) begin
          byte_no = int'(p / 8);
          if (byte_no == 0) begin
            if (m_win == FAS) begin
              if (m_mode == 1) m_mode = 2;
              m_misses = 0;
            end else if (m_mode == 1) begin
              model_hunt();
            end else begin
              m_misses++;
              if (m_misses >= LOSS) model_hunt();
            end
          end else if (byte_no == 1) begin
            if (m_prev_ok && m_win != m_crc_prev) begin
              e_err = 1;
              if (e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
            end
          end else begin
            m_pay.push_back(m_win);
            if (m_mode == 2) begin
              if (full) e_ovf = 1;
              else begin
                e_valid = 1;
                e_data  = m_win;
              end
            end
            if (byte_no == FB - 1) begin
              m_crc_prev = crc8_q(m_pay);
              m_prev_ok  = 1;
              m_pay.delete();
            end
          end
        end
      end
      m_idx++;
    end
    e_locked = (m_mode == 2);
  endtask

  task automatic checkOutput();
    check_val("locked", o_frame_locked, e_locked);
    check_val("pyld_valid", o_pyld_data_valid, e_valid);
    if (e_valid) check_val("pyld_data", o_pyld_data, e_data);
    check_val("ovf", o_ovf, e_ovf);
    check_val("crc_err", o_crc_err, e_err);
    check_val("crc_err_cnt", o_crc_err_cnt, e_cnt);
    if (o_pyld_data_valid === 1'b1) seen_valid++;
    if (o_ovf === 1'b1) seen_ovf++;
    if (o_crc_err === 1'b1) seen_err++;
  endtask

  task automatic applyStimulus(input logic b, input logic v, input logic full);
    i_frame_data       = b;
    i_frame_data_valid = v;
    i_fifo_full        = full;
    model_step(b, v, full);
    @(posedge i_clk);
    @(negedge i_clk);
    checkOutput();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic full, input int gap_pct);
    for (int i = 7; i >= 0; i--) begin
      for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++)
        applyStimulus(1'($urandom), 1'b0, 1'($urandom));
      applyStimulus(d[i], 1'b1, full);
    end
  endtask

  task automatic send_frame(input logic [7:0] fas, input logic [7:0] crc,
                            input logic [15:0] full_mask, input int gap_pct);
    send_byte(fas, full_mask[0], gap_pct);
    send_byte(crc, full_mask[1], gap_pct);
    foreach (pay[j]) send_byte(pay[j], full_mask[j+2], gap_pct);
    tx_crc = crc8_q(pay);
  endtask

  task automatic fill_pay(input int kind);
    pay.delete();
    for (int j = 0; j < FB - 2; j++)
      case (kind)
        0:       pay.push_back(8'h00);
        1:       pay.push_back(8'(j + 1));
        default: pay.push_back(8'($urandom));
      endcase
  endtask

  // Reset is asserted between clock edges so the clear is purely asynchronous.
  task automatic do_reset();
    #2 i_rst = 1'b0;
    i_frame_data_valid = 1'b0;
    #1;
    check_val("rst_locked", o_frame_locked, 1'b0);
    check_val("rst_valid", o_pyld_data_valid, 1'b0);
    check_val("rst_data", o_pyld_data, 8'h00);
    check_val("rst_ovf", o_ovf, 1'b0);
    check_val("rst_err", o_crc_err, 1'b0);
    check_val("rst_cnt", o_crc_err_cnt, 8'h00);
    model_reset();
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Clean all-zero frames: PRESYNC on frame 0, locked for frames 1 and 2.
    $display("[TB] step: zero frames");
    fill_pay(0);
    tx_crc = 8'h00;
    seen_valid = 0; seen_err = 0;
    repeat (3) send_frame(FAS, tx_crc, 16'h0000, 0);
    check_val("A_locked", o_frame_locked, 1'b1);
    check_val("A_bytes", seen_valid, 28);
    check_val("A_errs", seen_err, 0);

    // Wrong CRC after an all-zero payload.
    $display("[TB] step: crc error");
    send_frame(FAS, tx_crc, 16'h0000, 0);
    seen_valid = 0; seen_err = 0;
    send_frame(FAS, 8'h01, 16'h0000, 0);
    check_val("B_errs", seen_err, 1);
    check_val("B_cnt", o_crc_err_cnt, 8'd1);
    check_val("B_bytes", seen_valid, 14);

    // Random prefix of 19 bits, then ramp payload frames.
    $display("[TB] step: offset lock");
    do_reset();
    for (int i = 0; i < 19; i++) applyStimulus(1'($urandom), 1'b1, 1'b0);
    fill_pay(1);
    tx_crc = 8'($urandom);
    repeat (4) send_frame(FAS, tx_crc, 16'h0000, 0);

    // FAS corruption below and at the loss threshold, then relock.
    $display("[TB] step: fas loss");
    do_reset();
    fill_pay(0);
    tx_crc = 8'h00;
    repeat (2) send_frame(FAS, tx_crc, 16'h0000, 0);
    repeat (2) send_frame(8'h00, tx_crc, 16'h0000, 0);
    check_val("D_hold_lock", o_frame_locked, 1'b1);
    send_frame(FAS, tx_crc, 16'h0000, 0);
    repeat (2) send_frame(8'h00, tx_crc, 16'h0000, 0);
    seen_valid = 0;
    send_frame(8'h00, tx_crc, 16'h0000, 0);
    check_val("D_lost", o_frame_locked, 1'b0);
    check_val("D_no_bytes", seen_valid, 0);
    send_frame(FAS, 8'h55, 16'h0000, 0);
    repeat (2) send_frame(FAS, tx_crc, 16'h0000, 0);
    check_val("D_relock", o_frame_locked, 1'b1);
    check_val("D_cnt", o_crc_err_cnt, 8'd0);

    // FIFO full across frame bytes 5..7.
    $display("[TB] step: fifo full");
    fill_pay(2);
    seen_valid = 0; seen_ovf = 0;
    send_frame(FAS, tx_crc, 16'h00E0, 0);
    check_val("E_ovf", seen_ovf, 3);
    check_val("E_bytes", seen_valid, 11);
    send_frame(FAS, tx_crc, 16'h0000, 0);
    check_val("E_cnt", o_crc_err_cnt, 8'd0);

    // Valid gaps, reset mid-payload, relock with gaps.
    $display("[TB] step: gaps and reset");
    fill_pay(2);
    send_frame(FAS, tx_crc, 16'h0000, 30);
    send_byte(FAS, 1'b0, 30);
    send_byte(tx_crc, 1'b0, 30);
    for (int j = 0; j < 5; j++) send_byte(pay[j], 1'b0, 30);
    do_reset();
    for (int i = 0; i < 5; i++) applyStimulus(1'($urandom), 1'b1, 1'b0);
    for (int f = 0; f < 4; f++) begin
      fill_pay(2);
      send_frame(FAS, tx_crc, 16'h0000, 25);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
